// File: rtl/cb_seg_engine.sv
// Code-block segmentation engine: derives C/K/F from the TB size with iterative
// dividers, then streams filler, data and per-block CRC24B bits with framing flags.
module cb_seg_engine #(
   parameter int unsigned      SW   = 16,
   parameter int unsigned      ZMAX = 6144,
   parameter int unsigned      CRCL = 24,
   parameter logic [CRCL-1:0]  POLY = 24'h800063,
   parameter int unsigned      GRAN = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [SW-1:0] size_in,
   input  logic          size_valid,
   output logic          size_ready,
   input  logic          tb_in,
   input  logic          tb_valid,
   output logic          tb_ready,
   output logic          out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_start,
   output logic          out_last,
   output logic          out_filling,
   output logic          out_crc,
   output logic [7:0]    out_cb_idx,
   output logic [SW-1:0] out_cb_size,
   output logic          busy,
   output logic          err
);

   localparam int unsigned CW  = $clog2(CRCL);
   localparam int unsigned DCW = $clog2(SW);
   localparam logic [SW-1:0] ONE    = SW'(1);
   localparam logic [SW-1:0] ZMAX_W = SW'(ZMAX);
   localparam logic [SW-1:0] DIVC_W = SW'(ZMAX - CRCL);
   localparam logic [SW-1:0] CRCL_W = SW'(CRCL);
   localparam logic [SW-1:0] GMASK  = SW'(GRAN - 1);
   localparam logic [SW-1:0] BMAX   = SW'((1 << SW) - 1 - ZMAX);

   typedef enum logic [2:0] {IDLE, DIV_C, DIV_K, ROUND, FILL, DATA, CRC, NEXT} state_t;

   state_t          state;
   logic [SW-1:0]   b_reg, bp_reg, c_reg, lp_reg, kraw_reg, k_reg, f_reg, bit_cnt;
   logic [7:0]      cb_idx;
   logic [CRCL-1:0] crc;
   logic [CW-1:0]   crc_cnt;
   logic [SW-1:0]   div_n, div_r, div_d;
   logic [DCW-1:0]  div_cnt;

   // Restoring divider step: dividend shifts out of div_n while quotient bits shift in.
   logic [SW:0]     rem_sh;
   logic            q_bit;
   logic [SW-1:0]   rem_nx, quo_nx, ceil_nx, bp_nx, k_nx, f_nx, idx_ext;
   logic            multi, more_blk, data_end, blk_last, crc_feed;
   logic [CRCL-1:0] crc_nx;
   logic [CW-1:0]   crc_sel;

   assign rem_sh   = {div_r, div_n[SW-1]};
   assign q_bit    = rem_sh >= {1'b0, div_d};
   assign rem_nx   = q_bit ? SW'(rem_sh - {1'b0, div_d}) : rem_sh[SW-1:0];
   assign quo_nx   = {div_n[SW-2:0], q_bit};
   assign ceil_nx  = quo_nx + {{(SW-1){1'b0}}, (rem_nx != '0)};
   assign bp_nx    = b_reg + ceil_nx * CRCL_W;
   assign k_nx     = (kraw_reg + GMASK) & ~GMASK;
   assign f_nx     = c_reg * k_nx - bp_reg;

   assign idx_ext  = {{(SW-8){1'b0}}, cb_idx};
   assign multi    = c_reg != ONE;
   assign more_blk = idx_ext < (c_reg - ONE);
   assign data_end = bit_cnt == (k_reg - lp_reg - ONE);
   assign blk_last = bit_cnt == (k_reg - ONE);

   assign crc_feed = (state == DATA) ? tb_in : 1'b0;
   assign crc_nx   = {crc[CRCL-2:0], 1'b0} ^ ((crc[CRCL-1] ^ crc_feed) ? POLY : '0);
   assign crc_sel  = CW'(CRCL - 1) - crc_cnt;

   assign size_ready  = state == IDLE;
   assign busy        = state != IDLE;
   assign out_cb_idx  = cb_idx;
   assign out_cb_size = k_reg;

   // Every stream transfers on valid && ready; in DATA the bit passes straight through,
   // so an upstream stall only drops out_valid and the framing counters simply wait.
   always_comb begin
      out_valid   = 1'b0;
      out_data    = 1'b0;
      out_start   = 1'b0;
      out_last    = 1'b0;
      out_filling = 1'b0;
      out_crc     = 1'b0;
      tb_ready    = 1'b0;
      case (state)
         FILL: begin
            out_valid   = 1'b1;
            out_filling = 1'b1;
            out_start   = bit_cnt == '0;
            out_last    = blk_last;
         end
         DATA: begin
            out_valid = tb_valid;
            out_data  = tb_in;
            tb_ready  = out_ready;
            out_start = bit_cnt == '0;
            out_last  = blk_last;
         end
         CRC: begin
            out_valid = 1'b1;
            out_crc   = 1'b1;
            out_data  = crc[crc_sel];
            out_last  = blk_last;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         b_reg    <= '0;
         bp_reg   <= '0;
         c_reg    <= '0;
         lp_reg   <= '0;
         kraw_reg <= '0;
         k_reg    <= '0;
         f_reg    <= '0;
         bit_cnt  <= '0;
         cb_idx   <= '0;
         crc      <= '0;
         crc_cnt  <= '0;
         div_n    <= '0;
         div_r    <= '0;
         div_d    <= '0;
         div_cnt  <= '0;
         err      <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: if (size_valid) begin
               b_reg  <= size_in;
               k_reg  <= '0;
               cb_idx <= '0;
               if (size_in == '0 || size_in > BMAX) begin
                  err <= 1'b1;
               end else if (size_in <= ZMAX_W) begin
                  c_reg  <= ONE;
                  lp_reg <= '0;
                  bp_reg <= size_in;
                  state  <= DIV_K;
               end else begin
                  div_n   <= size_in;
                  div_r   <= '0;
                  div_d   <= DIVC_W;
                  div_cnt <= '0;
                  state   <= DIV_C;
               end
            end
            DIV_C: begin
               div_n   <= quo_nx;
               div_r   <= rem_nx;
               div_cnt <= div_cnt + DCW'(1);
               if (div_cnt == DCW'(SW - 1)) begin
                  // C is final here, so the K division is loaded with B' = B + C*L directly.
                  c_reg   <= ceil_nx;
                  lp_reg  <= CRCL_W;
                  bp_reg  <= bp_nx;
                  div_n   <= bp_nx;
                  div_r   <= '0;
                  div_d   <= ceil_nx;
                  div_cnt <= '0;
                  state   <= DIV_K;
               end
            end
            DIV_K: begin
               if (c_reg == ONE) begin
                  kraw_reg <= bp_reg;
                  state    <= ROUND;
               end else begin
                  div_n   <= quo_nx;
                  div_r   <= rem_nx;
                  div_cnt <= div_cnt + DCW'(1);
                  if (div_cnt == DCW'(SW - 1)) begin
                     kraw_reg <= ceil_nx;
                     state    <= ROUND;
                  end
               end
            end
            ROUND: begin
               k_reg   <= k_nx;
               f_reg   <= f_nx;
               cb_idx  <= '0;
               bit_cnt <= '0;
               crc     <= '0;
               crc_cnt <= '0;
               state   <= (f_nx != '0) ? FILL : DATA;
            end
            FILL: if (out_ready) begin
               if (multi) crc <= crc_nx;
               bit_cnt <= bit_cnt + ONE;
               if (bit_cnt == f_reg - ONE) state <= DATA;
            end
            DATA: if (tb_valid && out_ready) begin
               if (multi) crc <= crc_nx;
               bit_cnt <= bit_cnt + ONE;
               if (data_end) begin
                  if (multi) begin
                     crc_cnt <= '0;
                     state   <= CRC;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            CRC: if (out_ready) begin
               crc_cnt <= crc_cnt + CW'(1);
               bit_cnt <= bit_cnt + ONE;
               if (crc_cnt == CW'(CRCL - 1)) begin
                  crc <= '0;
                  if (more_blk) begin
                     cb_idx  <= cb_idx + 8'd1;
                     bit_cnt <= '0;
                     state   <= DATA;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
